// File: rtl/alu_pkg.sv
// Shared opcode encodings, shifter modes and width default for the RV32I
// execute-stage ALU and the decode/pipeline logic that drives it.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 4'b0000;
  localparam alu_op_t ALU_SUB    = 4'b0001;
  localparam alu_op_t ALU_AND    = 4'b0010;
  localparam alu_op_t ALU_OR     = 4'b0011;
  localparam alu_op_t ALU_XOR    = 4'b0100;
  localparam alu_op_t ALU_SLL    = 4'b0101;
  localparam alu_op_t ALU_SRL    = 4'b0110;
  localparam alu_op_t ALU_SRA    = 4'b0111;
  localparam alu_op_t ALU_SLT    = 4'b1000;
  localparam alu_op_t ALU_SLTU   = 4'b1001;
  localparam alu_op_t ALU_COPY_B = 4'b1111;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_mode_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the EX-stage issue logic (master) and the ALU (slave).
// valid_i qualifies op1_i/op2_i/alu_op_i; there is no ready, the ALU accepts every cycle.
interface alu_if
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  alu_op_t         alu_op_i;
  logic            valid_i;
  logic [XLEN-1:0] alu_result_o;
  logic            zero_o;
  logic            illegal_op_o;
  logic [XLEN-1:0] result_q_o;
  logic            zero_q_o;
  logic            valid_q_o;

  modport master (
    output op1_i, op2_i, alu_op_i, valid_i,
    input  alu_result_o, zero_o, illegal_op_o, result_q_o, zero_q_o, valid_q_o
  );

  modport slave (
    input  op1_i, op2_i, alu_op_i, valid_i,
    output alu_result_o, zero_o, illegal_op_o, result_q_o, zero_q_o, valid_q_o
  );

endinterface

// File: rtl/alu_shifter.sv
// Log-stage barrel shifter for SLL/SRL/SRA. Left shifts reuse the right-shift
// stages by bit-reversing the operand on the way in and the result on the way out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [XLEN-1:0]    value,
  input  logic [SHAMT_W-1:0] amount,
  input  shift_mode_t        mode,
  output logic [XLEN-1:0]    result
);

  logic            left;
  logic            fill;
  logic [XLEN-1:0] value_rev;
  logic [XLEN-1:0] post;
  logic [XLEN-1:0] post_rev;
  logic [XLEN-1:0] stg [SHAMT_W+1];

  assign left = (mode == SH_SLL);
  // Only SRA pulls in the sign bit; SLL and SRL shift in zeros.
  assign fill = (mode == SH_SRA) & value[XLEN-1];

  for (genvar b = 0; b < XLEN; b++) begin : g_rev
    assign value_rev[b] = value[XLEN-1-b];
    assign post_rev[b]  = post[XLEN-1-b];
  end

  assign stg[0] = left ? value_rev : value;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int STEP = 1 << s;
    assign stg[s+1] = amount[s] ? {{STEP{fill}}, stg[s][XLEN-1:STEP]} : stg[s];
  end

  assign post   = stg[SHAMT_W];
  assign result = left ? post_rev : post;

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: combinational result/zero/illegal for EX-stage use and
// forwarding, plus a registered copy with valid for the EX/MEM boundary.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic  clk_i,
  input logic  rst_n_i,
  alu_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            lt_signed;
  logic            lt_unsigned;
  shift_mode_t     sh_mode;
  logic [XLEN-1:0] sh_result;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            valid_q;

  // Shift mode is decoded outside the result mux so the shifter output does
  // not feed back into the process that selects it.
  assign sh_mode = (bus.alu_op_i == ALU_SRA) ? SH_SRA :
                   (bus.alu_op_i == ALU_SRL) ? SH_SRL : SH_SLL;

  alu_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .value  (bus.op1_i),
    .amount (bus.op2_i[SHAMT_W-1:0]),
    .mode   (sh_mode),
    .result (sh_result)
  );

  assign lt_signed   = $signed(bus.op1_i) < $signed(bus.op2_i);
  assign lt_unsigned = bus.op1_i < bus.op2_i;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (bus.alu_op_i)
      ALU_ADD:    result = bus.op1_i + bus.op2_i;
      ALU_SUB:    result = bus.op1_i - bus.op2_i;
      ALU_AND:    result = bus.op1_i & bus.op2_i;
      ALU_OR:     result = bus.op1_i | bus.op2_i;
      ALU_XOR:    result = bus.op1_i ^ bus.op2_i;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:    result = sh_result;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_COPY_B: result = bus.op2_i;
      default:    illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

  // Reset wins over a simultaneous valid_i; result/zero only load on valid_i.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        result_q <= result;
        zero_q   <= zero;
      end
    end
  end

  assign bus.alu_result_o = result;
  assign bus.zero_o       = zero;
  assign bus.illegal_op_o = illegal;
  assign bus.result_q_o   = result_q;
  assign bus.zero_q_o     = zero_q;
  assign bus.valid_q_o    = valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors for every opcode, shift and
// compare edge cases, illegal codes, and the registered EX/MEM stage.
module tb_alu;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  alu_if #(.XLEN(XLEN)) bus ();

  alu #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] observed,
                       input logic [XLEN-1:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic v);
    bus.alu_op_i = op;
    bus.op1_i    = a;
    bus.op2_i    = b;
    bus.valid_i  = v;
  endtask

  task automatic vec(input string tag, input alu_op_t op, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                     input logic exp_zero, input logic exp_ill);
    drive(op, a, b, 1'b0);
    #1;
    check({tag, ".result"},  bus.alu_result_o, exp_res);
    check({tag, ".zero"},    {31'd0, bus.zero_o}, {31'd0, exp_zero});
    check({tag, ".illegal"}, {31'd0, bus.illegal_op_o}, {31'd0, exp_ill});
  endtask

  task automatic check_q(input string tag, input logic [XLEN-1:0] exp_res,
                         input logic exp_zero, input logic exp_valid);
    check({tag, ".result_q"}, bus.result_q_o, exp_res);
    check({tag, ".zero_q"},   {31'd0, bus.zero_q_o}, {31'd0, exp_zero});
    check({tag, ".valid_q"},  {31'd0, bus.valid_q_o}, {31'd0, exp_valid});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd1, 1'b1);

    // Reset held for two edges with valid_i high: reset must win.
    repeat (2) @(posedge clk);
    #1;
    check_q("reset", 32'h0, 1'b1, 1'b0);

    // Combinational vectors (reset still asserted; outputs must not care).
    @(negedge clk);
    vec("add_10_5",      ALU_ADD,  32'd10,        32'd5,         32'h0000000F, 1'b0, 1'b0);
    vec("sub_20_20",     ALU_SUB,  32'd20,        32'd20,        32'h00000000, 1'b1, 1'b0);
    vec("add_wrap",      ALU_ADD,  32'hFFFFFFFF,  32'd1,         32'h00000000, 1'b1, 1'b0);
    vec("sub_0_1",       ALU_SUB,  32'd0,         32'd1,         32'hFFFFFFFF, 1'b0, 1'b0);
    vec("and",           ALU_AND,  32'h0000F0F0,  32'h00000F0F,  32'h00000000, 1'b1, 1'b0);
    vec("or",            ALU_OR,   32'h0000F0F0,  32'h00000F0F,  32'h0000FFFF, 1'b0, 1'b0);
    vec("xor",           ALU_XOR,  32'hA5A5A5A5,  32'h5A5A5A5A,  32'hFFFFFFFF, 1'b0, 1'b0);
    vec("sll_f_2",       ALU_SLL,  32'h0000000F,  32'd2,         32'h0000003C, 1'b0, 1'b0);
    vec("srl_msb_1",     ALU_SRL,  32'h80000000,  32'd1,         32'h40000000, 1'b0, 1'b0);
    vec("sra_neg_1",     ALU_SRA,  32'hFFFFFFFE,  32'd1,         32'hFFFFFFFF, 1'b0, 1'b0);
    vec("sll_amt_0x21",  ALU_SLL,  32'h0000000F,  32'h00000021,  32'h0000001E, 1'b0, 1'b0);
    vec("sra_msb_31",    ALU_SRA,  32'h80000000,  32'd31,        32'hFFFFFFFF, 1'b0, 1'b0);
    vec("srl_msb_31",    ALU_SRL,  32'h80000000,  32'd31,        32'h00000001, 1'b0, 1'b0);
    vec("sll_1_31",      ALU_SLL,  32'h00000001,  32'd31,        32'h80000000, 1'b0, 1'b0);
    vec("sra_by_0",      ALU_SRA,  32'h12345678,  32'hFFFFFFE0,  32'h12345678, 1'b0, 1'b0);
    vec("sra_pos_4",     ALU_SRA,  32'h7FFFFFFF,  32'd4,         32'h07FFFFFF, 1'b0, 1'b0);
    vec("slt_5_10",      ALU_SLT,  32'd5,         32'd10,        32'h00000001, 1'b0, 1'b0);
    vec("slt_10_5",      ALU_SLT,  32'd10,        32'd5,         32'h00000000, 1'b1, 1'b0);
    vec("slt_m1_0",      ALU_SLT,  32'hFFFFFFFF,  32'd0,         32'h00000001, 1'b0, 1'b0);
    vec("slt_0_min",     ALU_SLT,  32'd0,         32'h80000000,  32'h00000000, 1'b1, 1'b0);
    vec("sltu_max_0",    ALU_SLTU, 32'hFFFFFFFF,  32'd0,         32'h00000000, 1'b1, 1'b0);
    vec("sltu_10_max",   ALU_SLTU, 32'd10,        32'hFFFFFFFF,  32'h00000001, 1'b0, 1'b0);
    vec("copy_b",        ALU_COPY_B, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hBBBBBBBB, 1'b0, 1'b0);
    vec("copy_b_zero",   ALU_COPY_B, 32'hAAAAAAAA, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
    vec("illegal_1010",  4'b1010,  32'd10,        32'd5,         32'h00000000, 1'b1, 1'b1);
    vec("illegal_1011",  4'b1011,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 1'b1, 1'b1);
    vec("illegal_1100",  4'b1100,  32'h12345678,  32'h1,         32'h00000000, 1'b1, 1'b1);
    vec("illegal_1101",  4'b1101,  32'h80000000,  32'h2,         32'h00000000, 1'b1, 1'b1);
    vec("illegal_1110",  4'b1110,  32'hA5A5A5A5,  32'h3,         32'h00000000, 1'b1, 1'b1);

    // Register stage: capture on valid, hold when not valid.
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_ADD, 32'd10, 32'd5, 1'b1);
    @(posedge clk);
    #1;
    check_q("reg_load", 32'h0000000F, 1'b0, 1'b1);

    @(negedge clk);
    drive(ALU_SUB, 32'd20, 32'd20, 1'b0);
    @(posedge clk);
    #1;
    check_q("reg_hold", 32'h0000000F, 1'b0, 1'b0);

    @(negedge clk);
    drive(ALU_SUB, 32'd20, 32'd20, 1'b1);
    @(posedge clk);
    #1;
    check_q("reg_zero", 32'h00000000, 1'b1, 1'b1);

    @(negedge clk);
    drive(ALU_XOR, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    @(posedge clk);
    #1;
    check_q("reg_xor", 32'hFFFFFFFF, 1'b0, 1'b1);

    // Reset overrides a simultaneous valid_i.
    @(negedge clk);
    rst_n = 1'b0;
    drive(ALU_ADD, 32'd10, 32'd5, 1'b1);
    @(posedge clk);
    #1;
    check_q("reset_over_valid", 32'h0, 1'b1, 1'b0);
    check("comb_in_reset", bus.alu_result_o, 32'h0000000F);

    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check_q("post_reset_idle", 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
